// File: rtl/codec_i2c_config.sv
// codec_i2c_config: WM8731 I2C init-table sequencer with host register writes.
// Define CODEC_CFG_RETRY_EN to retry a NACKed transaction up to MAX_RETRY times.
module codec_i2c_config #(
    parameter int         CLK_DIV   = 125,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       wr_req,
    input  logic [6:0] wr_addr,
    input  logic [8:0] wr_data,
    output logic       wr_ack,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       i2c_sclk,
    output logic       i2c_sdat_oe,
    input  logic       i2c_sdat_i
);
    typedef enum logic [2:0] {IDLE, LOAD, START, BITS, ACK, STOP, GAP, FAIL} state_t;
    localparam int TW = $clog2(CLK_DIV);
    localparam logic [15:0] INIT_TABLE [11] = '{
        {7'h0F, 9'h000}, {7'h00, 9'h017}, {7'h01, 9'h017}, {7'h02, 9'h079},
        {7'h03, 9'h079}, {7'h04, 9'h012}, {7'h05, 9'h000}, {7'h06, 9'h000},
        {7'h07, 9'h001}, {7'h08, 9'h000}, {7'h09, 9'h001}
    };

    if (CLK_DIV < 2 || MAX_RETRY < 0) begin : g_param_check
        $error("codec_i2c_config: CLK_DIV must be >= 2 and MAX_RETRY >= 0");
    end

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [1:0]      q_q, q_d;
    logic [2:0]      bitn_q, bitn_d;
    logic [1:0]      byten_q, byten_d;
    logic [7:0]      sh_q, sh_d;
    logic [15:0]     pay_q, pay_d;
    logic [3:0]      idx_q, idx_d;
    logic            host_q, host_d, fail_q, fail_d, nack_q, nack_d, boot_q, boot_d;
    logic            done_q, done_d, err_q, err_d, ack_q, ack_d;
    logic            sclk_q, sclk_d, oe_q, oe_d;
    logic            tick_wrap, slot_end;
`ifdef CODEC_CFG_RETRY_EN
    localparam int RW = $clog2(MAX_RETRY + 2);
    logic [RW-1:0]   retry_q, retry_d;
`endif

    assign tick_wrap   = tick_q == TW'(CLK_DIV - 1);
    assign slot_end    = tick_wrap && q_q == 2'd3;
    assign busy        = !(state_q inside {IDLE, FAIL}) || (boot_q && !reset);
    assign wr_ack      = ack_q;
    assign done        = done_q;
    assign err         = err_q;
    assign i2c_sclk    = sclk_q;
    assign i2c_sdat_oe = oe_q;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        q_d     = q_q;
        bitn_d  = bitn_q;
        byten_d = byten_q;
        sh_d    = sh_q;
        pay_d   = pay_q;
        idx_d   = idx_q;
        host_d  = host_q;
        fail_d  = fail_q;
        nack_d  = nack_q;
        boot_d  = boot_q;
        done_d  = done_q;
        err_d   = err_q;
        ack_d   = 1'b0;
`ifdef CODEC_CFG_RETRY_EN
        retry_d = retry_q;
`endif
        if (state_q inside {START, BITS, ACK, STOP, GAP}) begin
            tick_d = tick_wrap ? '0 : tick_q + 1'b1;
            q_d    = tick_wrap ? q_q + 1'b1 : q_q;
        end
        if (state_q == ACK && tick_wrap && q_q == 2'd2) nack_d = i2c_sdat_i;
        case (state_q)
            IDLE, FAIL: begin
                if (start || boot_q) begin
                    state_d = LOAD;
                    idx_d   = '0;
                    host_d  = 1'b0;
                    boot_d  = 1'b0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (state_q == IDLE && wr_req && done_q && !err_q && !ack_q) begin
                    state_d = LOAD;
                    host_d  = 1'b1;
                end
            end
            LOAD: begin
                state_d = START;
                pay_d   = host_q ? {wr_addr, wr_data} : INIT_TABLE[idx_q];
                sh_d    = {DEV_ADDR, 1'b0};
                tick_d  = '0;
                q_d     = '0;
                bitn_d  = '0;
                byten_d = '0;
                fail_d  = 1'b0;
            end
            START: if (slot_end) state_d = BITS;
            BITS: if (slot_end) begin
                sh_d    = {sh_q[6:0], 1'b0};
                bitn_d  = bitn_q + 1'b1;
                state_d = bitn_q == 3'd7 ? ACK : BITS;
            end
            ACK: if (slot_end) begin
                if (nack_q || byten_q == 2'd2) begin
                    state_d = STOP;
                    fail_d  = nack_q;
                end else begin
                    state_d = BITS;
                    byten_d = byten_q + 1'b1;
                    sh_d    = byten_q == 2'd0 ? pay_q[15:8] : pay_q[7:0];
                end
            end
            STOP: if (slot_end) begin
`ifdef CODEC_CFG_RETRY_EN
                state_d = GAP;
`else
                state_d = fail_q ? FAIL : GAP;
                err_d   = err_q | fail_q;
                ack_d   = fail_q & host_q;
`endif
            end
            GAP: if (slot_end) begin
`ifdef CODEC_CFG_RETRY_EN
                retry_d = '0;
                if (fail_q && retry_q != RW'(MAX_RETRY)) begin
                    state_d = LOAD;
                    retry_d = retry_q + 1'b1;
                end else if (fail_q) begin
                    state_d = FAIL;
                    err_d   = 1'b1;
                    ack_d   = host_q;
                end else
`endif
                if (host_q || idx_q == 4'd10) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ack_d   = host_q;
                end else begin
                    state_d = LOAD;
                    idx_d   = idx_q + 1'b1;
                end
            end
        endcase
        // Pin levels are registered from the next state so they switch with the slot phase
        sclk_d = !(state_d inside {BITS, ACK} && !q_d[1]) && !(state_d == STOP && q_d == 2'd0);
        oe_d   = (state_d == START && q_d[1]) || (state_d == BITS && !sh_d[7]) ||
                 (state_d == STOP && !q_d[1]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            q_q     <= '0;
            bitn_q  <= '0;
            byten_q <= '0;
            sh_q    <= '0;
            pay_q   <= '0;
            idx_q   <= '0;
            host_q  <= 1'b0;
            fail_q  <= 1'b0;
            nack_q  <= 1'b0;
            boot_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            sclk_q  <= 1'b1;
            oe_q    <= 1'b0;
`ifdef CODEC_CFG_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            q_q     <= q_d;
            bitn_q  <= bitn_d;
            byten_q <= byten_d;
            sh_q    <= sh_d;
            pay_q   <= pay_d;
            idx_q   <= idx_d;
            host_q  <= host_d;
            fail_q  <= fail_d;
            nack_q  <= nack_d;
            boot_q  <= boot_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            sclk_q  <= sclk_d;
            oe_q    <= oe_d;
`ifdef CODEC_CFG_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end
endmodule

// File: tb/tb_codec_i2c_config.sv
// tb_codec_i2c_config: I2C slave model + byte-stream reference for codec_i2c_config.
// Honours CODEC_CFG_RETRY_EN to select NACK expectations.
module tb_codec_i2c_config;
    localparam int CD = 4;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, wr_req = 1'b0;
    logic [6:0] wr_addr = '0;
    logic [8:0] wr_data = '0;
    logic wr_ack, busy, done, err, i2c_sclk, i2c_sdat_oe, i2c_sdat_i;
    logic slave_pull = 1'b0;
    int checks = 0, errors = 0;
    logic [7:0] got[$], exp_q[$];
    int starts = 0, stops = 0, ack_cnt = 0, first_len = 0, t0 = 0, cyc = 0;
    int bitc = 0, nbyte = 0, nack_tx = 0, nack_byte = 0, nack_left = 0;
    logic in_tx = 1'b0, scl_p = 1'b1, sda_p = 1'b1, sda_c;
    logic [7:0] sh = '0;
    logic [6:0] t_addr [11] = '{7'h0F, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h08, 7'h09};
    logic [8:0] t_data [11] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h000, 9'h001, 9'h000, 9'h001};
    string nm [6] = '{"wr_ack", "err", "done", "busy", "oe", "sclk"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    assign i2c_sdat_i = !(i2c_sdat_oe || slave_pull);

    codec_i2c_config #(.CLK_DIV(CD)) dut (
        .clk(clk), .reset(reset), .start(start), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy), .done(done), .err(err),
        .i2c_sclk(i2c_sclk), .i2c_sdat_oe(i2c_sdat_oe), .i2c_sdat_i(i2c_sdat_i)
    );

    // Bus-level slave: decodes START/STOP/bytes and answers ACK or NACK
    always @(negedge clk) begin
        sda_c = !(i2c_sdat_oe || slave_pull);
        if (wr_ack) ack_cnt++;
        if (i2c_sclk && scl_p && sda_p && !sda_c) begin
            in_tx = 1'b1; bitc = 0; nbyte = 0; starts++; t0 = cyc;
        end else if (i2c_sclk && scl_p && !sda_p && sda_c) begin
            in_tx = 1'b0; stops++;
            if (stops == 1) first_len = cyc - t0;
        end else if (in_tx && i2c_sclk && !scl_p) begin
            if (bitc < 8) sh = {sh[6:0], sda_c};
            bitc++;
        end else if (in_tx && !i2c_sclk && scl_p) begin
            if (bitc == 8) begin
                got.push_back(sh);
                slave_pull = !(nack_left > 0 && starts - 1 >= nack_tx && nbyte == nack_byte);
                if (!slave_pull) nack_left--;
                nbyte++;
            end else if (bitc == 9) begin
                slave_pull = 1'b0; bitc = 0;
            end
        end
        scl_p = i2c_sclk;
        sda_p = !(i2c_sdat_oe || slave_pull);
    end

    function automatic void push_entry(input logic [6:0] a, input logic [8:0] d, input int n);
        logic [7:0] b [3];
        b[0] = 8'h34; b[1] = {a, d[8]}; b[2] = d[7:0];
        for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
    endfunction

    function automatic void push_table();
        for (int i = 0; i < 11; i++) push_entry(t_addr[i], t_data[i], 3);
    endfunction

    task automatic clear_mon();
        @(posedge clk); #1;
        got.delete(); exp_q.delete();
        starts = 0; stops = 0; ack_cnt = 0; in_tx = 1'b0; bitc = 0; slave_pull = 1'b0; nack_left = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] v, e;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        v = {i2c_sclk, i2c_sdat_oe, busy, done, err, wr_ack};
        e = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (v[i] !== e[i]) begin errors++; $display("FAIL reset_%s got=%b exp=%b", nm[i], v[i], e[i]); end
        end
    endtask

    task automatic test_init();
        int n;
        clear_mon();
        push_table();
        @(negedge clk); reset = 1'b0; #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL init_busy got=%b exp=1", busy); end
        for (n = 0; n < 7000 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || n < 5280 || n > 5300) begin
            errors++; $display("FAIL init_done_time done=%b cycles=%0d exp=5280..5300", done, n);
        end
        checks++;
        if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL init_flags err=%b busy=%b exp=0,0", err, busy); end
        checks++;
        if (stops != 11) begin errors++; $display("FAIL init_stops got=%0d exp=11", stops); end
        checks++;
        if (first_len != 28 * 4 * CD) begin errors++; $display("FAIL init_tx_len got=%0d exp=%0d", first_len, 28 * 4 * CD); end
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL init_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL init_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_host_write();
        int n;
        for (int k = 0; k < 4; k++) begin
            clear_mon();
            @(negedge clk);
            wr_addr = k == 0 ? 7'h02 : 7'($urandom);
            wr_data = k == 0 ? 9'h07F : 9'($urandom);
            push_entry(wr_addr, wr_data, 3);
            wr_req = 1'b1;
            for (n = 0; n < 1000 && wr_ack !== 1'b1; n++) @(negedge clk);
            wr_req = 1'b0;
            checks++;
            if (wr_ack !== 1'b1) begin errors++; $display("FAIL host%0d_ack_timeout wr_ack=%b exp=1", k, wr_ack); end
            repeat (10) @(negedge clk);
            checks++;
            if (ack_cnt != 1 || busy !== 1'b0 || done !== 1'b1) begin
                errors++; $display("FAIL host%0d_after acks=%0d busy=%b done=%b exp=1,0,1", k, ack_cnt, busy, done);
            end
            checks++;
            if (got.size() != exp_q.size()) begin errors++; $display("FAIL host%0d_len got=%0d exp=%0d", k, got.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin errors++; $display("FAIL host%0d_byte%0d got=%h exp=%h", k, i, got[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_start_pending();
        int n;
        clear_mon();
        @(negedge clk);
        wr_addr = 7'($urandom); wr_data = 9'($urandom);
        push_table();
        push_entry(wr_addr, wr_data, 3);
        start = 1'b1; wr_req = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL pend_restart done=%b busy=%b exp=0,1", done, busy); end
        for (n = 0; n < 8000 && wr_ack !== 1'b1; n++) @(negedge clk);
        wr_req = 1'b0;
        checks++;
        if (wr_ack !== 1'b1 || done !== 1'b1 || err !== 1'b0) begin
            errors++; $display("FAIL pend_ack wr_ack=%b done=%b err=%b exp=1,1,0", wr_ack, done, err);
        end
        checks++;
        if (stops != 12) begin errors++; $display("FAIL pend_stops got=%0d exp=12", stops); end
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL pend_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL pend_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [5:0] v, e;
        clear_mon();
        pulse_start();
        for (n = 0; n < 4000 && stops < 5; n++) @(negedge clk);
        repeat (25 + 14 * 4 * CD) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        v = {i2c_sclk, i2c_sdat_oe, busy, done, err, wr_ack};
        e = 6'b100000;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (v[i] !== e[i]) begin errors++; $display("FAIL midrst_%s got=%b exp=%b", nm[i], v[i], e[i]); end
        end
        clear_mon();
        push_entry(t_addr[0], t_data[0], 3);
        @(negedge clk); reset = 1'b0;
        for (n = 0; n < 1000 && stops < 1; n++) @(negedge clk);
        checks++;
        if (got.size() < 3) begin errors++; $display("FAIL midrst_len got=%0d exp>=3", got.size()); end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        for (n = 0; n < 7000 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL midrst_done got=%b exp=1", done); end
    endtask

    task automatic test_nack();
        int n;
`ifdef CODEC_CFG_RETRY_EN
        clear_mon();
        nack_tx = 0; nack_byte = 0; nack_left = 2;
        push_entry(t_addr[0], t_data[0], 1);
        push_entry(t_addr[0], t_data[0], 1);
        push_table();
        pulse_start();
        for (n = 0; n < 8000 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL retry_ok done=%b err=%b exp=1,0", done, err); end
        checks++;
        if (stops != 13) begin errors++; $display("FAIL retry_ok_stops got=%0d exp=13", stops); end
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL retry_ok_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL retry_ok_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        clear_mon();
        nack_tx = 0; nack_byte = 0; nack_left = 4;
        for (int i = 0; i < 4; i++) push_entry(t_addr[0], t_data[0], 1);
        pulse_start();
`else
        clear_mon();
        nack_tx = 3; nack_byte = 1; nack_left = 1;
        for (int i = 0; i < 3; i++) push_entry(t_addr[i], t_data[i], 3);
        push_entry(t_addr[3], t_data[3], 2);
        pulse_start();
`endif
        for (n = 0; n < 5000 && err !== 1'b1; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        checks++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL nack_flags err=%b done=%b busy=%b exp=1,0,0", err, done, busy);
        end
        checks++;
        if (i2c_sdat_oe !== 1'b0 || i2c_sclk !== 1'b1) begin
            errors++; $display("FAIL nack_bus oe=%b sclk=%b exp=0,1", i2c_sdat_oe, i2c_sclk);
        end
        checks++;
        if (stops != starts || stops != (exp_q.size() == 4 ? 4 : 4)) begin
            errors++; $display("FAIL nack_stops stops=%0d starts=%0d exp=4", stops, starts);
        end
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL nack_len got=%0d exp=%0d", got.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin errors++; $display("FAIL nack_byte%0d got=%h exp=%h", i, got[i], exp_q[i]); end
        end
        @(negedge clk); wr_req = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack_cnt != 0 || starts != 4) begin
            errors++; $display("FAIL nack_req_blocked busy=%b acks=%0d starts=%0d exp=0,0,4", busy, ack_cnt, starts);
        end
        wr_req = 1'b0;
    endtask

    task automatic test_host_fail();
        int n;
        clear_mon();
        pulse_start();
        for (n = 0; n < 7000 && done !== 1'b1; n++) @(negedge clk);
        checks++;
        if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL recover done=%b err=%b exp=1,0", done, err); end
        clear_mon();
        nack_tx = 0; nack_byte = 2; nack_left = 100;
        @(negedge clk);
        wr_addr = 7'($urandom); wr_data = 9'($urandom); wr_req = 1'b1;
        for (n = 0; n < 4000 && wr_ack !== 1'b1; n++) @(negedge clk);
        wr_req = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (err !== 1'b1 || ack_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL host_nack err=%b acks=%0d busy=%b exp=1,1,0", err, ack_cnt, busy);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_host_write();
        test_start_pending();
        test_reset_mid();
        test_nack();
        test_host_fail();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
